mul_twf_pipe: RTL and testbench
===============================

MUL_TWF_PIPE -- requirements
Module: mul_twf_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 11, signed input sample width (real and quadrature).
REQ-002 SHALL have parameter TWF_WIDTH, default 10, signed twiddle coefficient width (Q8, unity = 256).
REQ-003 SHALL have parameter FRAC, default 8, arithmetic right-shift applied to products.
REQ-004 SHALL have parameter DOUT_WIDTH, default WIDTH+TWF_WIDTH-FRAC (13), signed output width.
REQ-005 SHALL have parameter DEPTH, default 16, number of parallel lanes.
REQ-006 SHALL have one clock and an asynchronous active-low reset: clk (input, 1, rising-edge clock), then rst_n (input, 1, asynchronous active-low reset).
REQ-007 SHALL have ports din_valid (input, 1, input beat valid) and din_ready (output, 1, beat accepted when valid and ready both high).
REQ-008 SHALL have ports sof (input, 1, start of frame, sampled with the beat) and tw_auto (input, 1, 1 = internal twiddle index, 0 = select).
REQ-009 SHALL have ports select (input, 3, twiddle index k of W8^k) and rnd_en (input, 1, 1 = round half-up, 0 = truncate toward minus infinity).
REQ-010 SHALL have ports din_R_add, din_Q_add, din_R_sub, din_Q_sub (input, DEPTH x WIDTH signed, two complex streams per lane).
REQ-011 SHALL have ports dout_valid (output, 1) and dout_ready (input, 1, downstream accept).
REQ-012 SHALL have ports dout_R_add, dout_Q_add, dout_R_sub, dout_Q_sub (output, DEPTH x DOUT_WIDTH signed).
REQ-013 SHALL have ports tw_idx (output, 3, index used by the most recently accepted beat) and ovf (output, 1, sticky saturation flag).

Function
REQ-014 SHALL use twiddle table W8^k = cos(2*pi*k/8) - j*sin(2*pi*k/8), Q8: k0 (256,0), k1 (181,-181), k2 (0,-256), k3 (-181,-181), k4 (-256,0), k5 (-181,181), k6 (0,256), k7 (181,181).
REQ-015 SHALL compute per lane and per stream re = R*c - Q*d and im = R*d + Q*c at full precision, with (c,d) the selected twiddle.
REQ-016 SHALL, when rnd_en=1, add 2^(FRAC-1) before the arithmetic shift by FRAC; when rnd_en=0, shift only.
REQ-017 SHALL saturate each shifted result to the DOUT_WIDTH signed range and set ovf on any clamp; ovf clears only on reset.
REQ-018 SHALL be a 3-stage pipeline (input/twiddle register, products, sum/round/saturate), giving dout_valid 3 cycles after acceptance when there is no stall.
REQ-019 SHALL share one advance enable across the pipeline: en = !dout_valid || dout_ready; din_ready = en.
REQ-020 SHALL, when en=0, hold all pipeline registers and outputs stable, including dout_valid.
REQ-021 SHALL sample rnd_en, tw_auto and select with the accepted beat and carry them with it; mid-stream changes affect only later beats.
REQ-022 SHALL, when tw_auto=1, use internal counter auto_k: an accepted beat with sof=1 uses k=0 and sets auto_k=1; other accepted beats use auto_k, then auto_k increments mod 8 (7 wraps to 0).
REQ-023 SHALL, when tw_auto=0, use select, and sof=1 still resets auto_k to 1.
REQ-024 SHALL leave auto_k and tw_idx unchanged on cycles with no accepted beat.

Reset
REQ-025 SHALL, while rst_n=0, asynchronously clear dout_valid, all pipeline valid bits, all dout_* data, auto_k, tw_idx and ovf to 0.
REQ-026 SHALL hold din_ready=1 after reset (pipeline empty); a reset mid-stream discards in-flight beats without emitting them.

Structure
REQ-027 SHALL take the twiddle table, FRAC default and the saturate function from the shared package fft_pkg.
REQ-028 SHALL instantiate DEPTH copies of sub-module cmul_lane (one lane, both streams, 3 stages), with the enable, index counter and ovf OR-reduction in the top level.

Verification
REQ-029 SHALL check: R=10, Q=8 on all lanes and both streams, select=1, rnd_en=0 -> dout_R=12, dout_Q=-2 exactly 3 cycles later.
REQ-030 SHALL check: same stimulus with rnd_en=1 -> dout_R=13, dout_Q=-1.
REQ-031 SHALL check: DOUT_WIDTH=11, R=Q=1023, select=1 -> dout_R=1023 (clamped from 1446), dout_Q=0, ovf=1 and staying 1.
REQ-032 SHALL check: tw_auto=1, 10 back-to-back beats with sof on beat 0 -> tw_idx sequence 0,1,2,3,4,5,6,7,0,1.
REQ-033 SHALL check: dout_ready=0 for 4 cycles with the pipe full -> din_ready=0, outputs frozen, no beat lost or duplicated after release.
REQ-034 SHALL check: rst_n pulsed low with 2 beats in flight -> dout_valid=0 immediately, no output for those beats, auto_k=0.

Source files
------------

// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT datapath definitions.
//   FRAC_DEF      default fractional shift for Q8 twiddles
//   TW_C / TW_D   W8^k twiddle table (cos, -sin) in Q8, unity = 256
//   sat()         clamp a wide signed value to a w-bit signed range
package fft_pkg;
    localparam int FRAC_DEF = 8;
    localparam logic signed [15:0] TW_C [8] = '{16'sd256, 16'sd181, 16'sd0, -16'sd181,
                                               -16'sd256, -16'sd181, 16'sd0, 16'sd181};
    localparam logic signed [15:0] TW_D [8] = '{16'sd0, -16'sd181, -16'sd256, -16'sd181,
                                               16'sd0, 16'sd181, 16'sd256, 16'sd181};
    function automatic logic signed [63:0] sat(input logic signed [63:0] x, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        return x > hi ? hi : (x < lo ? lo : x);
    endfunction
endpackage

// File: rtl/cmul_lane.sv
// cmul_lane: one lane of the twiddle multiplier, two complex streams, three register stages.
//   clk, rst_n   clock, asynchronous active-low reset
//   en           shared pipeline advance enable
//   k, rnd       twiddle index and round enable travelling with the beat
//   din[4]       {R_add, Q_add, R_sub, Q_sub}
//   dout[4]      rotated, rounded/truncated and saturated results, same order
//   clamp        some result entering the output stage is being saturated
module cmul_lane
    import fft_pkg::*;
#(
    parameter int WIDTH      = 11,
    parameter int TWF_WIDTH  = 10,
    parameter int FRAC       = FRAC_DEF,
    parameter int DOUT_WIDTH = WIDTH + TWF_WIDTH - FRAC
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic [2:0]                   k,
    input  logic                         rnd,
    input  logic signed [WIDTH-1:0]      din  [4],
    output logic signed [DOUT_WIDTH-1:0] dout [4],
    output logic                         clamp
);
    localparam int PW = WIDTH + TWF_WIDTH;
    logic signed [WIDTH-1:0]      x_q    [4];
    logic signed [PW-1:0]         p_q    [8];
    logic signed [63:0]           y      [4];
    logic signed [63:0]           s_y    [4];
    logic signed [DOUT_WIDTH-1:0] dout_d [4];
    logic signed [TWF_WIDTH-1:0]  c, d;
    logic signed [63:0]           r;
    logic [2:0]                   k_q;
    logic                         rnd_q, rnd2_q;
    logic [3:0]                   cl;
    assign c = TWF_WIDTH'(TW_C[k_q]);
    assign d = TWF_WIDTH'(TW_D[k_q]);
    assign r = rnd2_q ? 64'sd1 <<< (FRAC - 1) : 64'sd0;
    assign clamp = |cl;
    // p_q per stream s: R*c, Q*d, R*d, Q*c -> re = p0 - p1, im = p2 + p3
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            y[2*s]   = (64'(p_q[4*s])   - 64'(p_q[4*s+1]) + r) >>> FRAC;
            y[2*s+1] = (64'(p_q[4*s+2]) + 64'(p_q[4*s+3]) + r) >>> FRAC;
        end
        for (int i = 0; i < 4; i++) begin
            s_y[i]    = sat(y[i], DOUT_WIDTH);
            dout_d[i] = DOUT_WIDTH'(s_y[i]);
            cl[i]     = s_y[i] != y[i];
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q    <= '{default: '0};
            p_q    <= '{default: '0};
            dout   <= '{default: '0};
            k_q    <= '0;
            rnd_q  <= 1'b0;
            rnd2_q <= 1'b0;
        end else if (en) begin
            x_q    <= din;
            k_q    <= k;
            rnd_q  <= rnd;
            rnd2_q <= rnd_q;
            for (int s = 0; s < 2; s++) begin
                p_q[4*s]   <= PW'(x_q[2*s])   * PW'(c);
                p_q[4*s+1] <= PW'(x_q[2*s+1]) * PW'(d);
                p_q[4*s+2] <= PW'(x_q[2*s])   * PW'(d);
                p_q[4*s+3] <= PW'(x_q[2*s+1]) * PW'(c);
            end
            dout <= dout_d;
        end
    end
endmodule

// File: rtl/mul_twf_pipe.sv
// mul_twf_pipe: DEPTH-lane complex multiply by W8^k with rounding, saturation and a
// 3-stage stallable pipeline.
//   clk, rst_n              clock, asynchronous active-low reset
//   din_valid/din_ready     input handshake (din_ready = shared advance enable)
//   sof, tw_auto, select    frame start, automatic/explicit twiddle index choice
//   rnd_en                  round half-up (1) or truncate (0)
//   din_*                   per-lane add/sub complex input streams
//   dout_valid/dout_ready   output handshake
//   dout_*                  per-lane results
//   tw_idx                  index used by the most recently accepted beat
//   ovf                     sticky saturation flag
module mul_twf_pipe
    import fft_pkg::*;
#(
    parameter int WIDTH      = 11,
    parameter int TWF_WIDTH  = 10,
    parameter int FRAC       = FRAC_DEF,
    parameter int DOUT_WIDTH = WIDTH + TWF_WIDTH - FRAC,
    parameter int DEPTH      = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         din_valid,
    output logic                         din_ready,
    input  logic                         sof,
    input  logic                         tw_auto,
    input  logic [2:0]                   select,
    input  logic                         rnd_en,
    input  logic signed [WIDTH-1:0]      din_R_add  [DEPTH],
    input  logic signed [WIDTH-1:0]      din_Q_add  [DEPTH],
    input  logic signed [WIDTH-1:0]      din_R_sub  [DEPTH],
    input  logic signed [WIDTH-1:0]      din_Q_sub  [DEPTH],
    output logic                         dout_valid,
    input  logic                         dout_ready,
    output logic signed [DOUT_WIDTH-1:0] dout_R_add [DEPTH],
    output logic signed [DOUT_WIDTH-1:0] dout_Q_add [DEPTH],
    output logic signed [DOUT_WIDTH-1:0] dout_R_sub [DEPTH],
    output logic signed [DOUT_WIDTH-1:0] dout_Q_sub [DEPTH],
    output logic [2:0]                   tw_idx,
    output logic                         ovf
);
    logic             en, acc, ovf_q;
    logic [2:0]       v_q, auto_k_q, tw_idx_q, k_d;
    logic [DEPTH-1:0] clamp;
    assign en         = !v_q[2] || dout_ready;
    assign din_ready  = en;
    assign acc        = din_valid && en;
    assign k_d        = tw_auto ? (sof ? 3'd0 : auto_k_q) : select;
    assign dout_valid = v_q[2];
    assign tw_idx     = tw_idx_q;
    assign ovf        = ovf_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q      <= '0;
            auto_k_q <= '0;
            tw_idx_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (en)
                v_q <= {v_q[1:0], din_valid};
            if (acc) begin
                tw_idx_q <= k_d;
                auto_k_q <= sof ? 3'd1 : (tw_auto ? auto_k_q + 3'd1 : auto_k_q);
            end
            // only a real beat moving into the output stage may raise the flag
            if (en && v_q[1] && (|clamp))
                ovf_q <= 1'b1;
        end
    end
    for (genvar i = 0; i < DEPTH; i++) begin : g_lane
        logic signed [WIDTH-1:0]      ld [4];
        logic signed [DOUT_WIDTH-1:0] lq [4];
        assign ld = '{din_R_add[i], din_Q_add[i], din_R_sub[i], din_Q_sub[i]};
        assign dout_R_add[i] = lq[0];
        assign dout_Q_add[i] = lq[1];
        assign dout_R_sub[i] = lq[2];
        assign dout_Q_sub[i] = lq[3];
        cmul_lane #(
            .WIDTH(WIDTH), .TWF_WIDTH(TWF_WIDTH), .FRAC(FRAC), .DOUT_WIDTH(DOUT_WIDTH)
        ) u_lane (
            .clk(clk), .rst_n(rst_n), .en(en), .k(k_d), .rnd(rnd_en),
            .din(ld), .dout(lq), .clamp(clamp[i])
        );
    end
endmodule

// File: tb/tb_mul_twf_pipe.sv
// tb_mul_twf_pipe: scoreboard bench for mul_twf_pipe (default widths and an 11-bit-output copy).
module tb_mul_twf_pipe;
    localparam int DEPTH = 16;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic din_valid = 1'b0, sof = 1'b0, tw_auto = 1'b0, rnd_en = 1'b0, dout_ready = 1'b1;
    logic [2:0] select = 3'd0;
    logic signed [10:0] dRa [DEPTH], dQa [DEPTH], dRs [DEPTH], dQs [DEPTH];
    logic signed [12:0] aRa [DEPTH], aQa [DEPTH], aRs [DEPTH], aQs [DEPTH];
    logic signed [10:0] bRa [DEPTH], bQa [DEPTH], bRs [DEPTH], bQs [DEPTH];
    logic din_ready, dout_valid, ovf, din_ready_s, dout_valid_s, ovf_s;
    logic [2:0] tw_idx, tw_idx_s;

    typedef struct { int v[2][64]; bit ov[2]; } exp_t;
    exp_t sb[$];
    int errors = 0, checks = 0;
    int m_auto = 0;
    bit m_ov[2] = '{0, 0};
    bit done = 0;
    int tc[8] = '{256, 181, 0, -181, -256, -181, 0, 181};
    int td[8] = '{0, -181, -256, -181, 0, 181, 256, 181};
    int seq[10] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};

    mul_twf_pipe dut (
        .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din_ready(din_ready),
        .sof(sof), .tw_auto(tw_auto), .select(select), .rnd_en(rnd_en),
        .din_R_add(dRa), .din_Q_add(dQa), .din_R_sub(dRs), .din_Q_sub(dQs),
        .dout_valid(dout_valid), .dout_ready(dout_ready),
        .dout_R_add(aRa), .dout_Q_add(aQa), .dout_R_sub(aRs), .dout_Q_sub(aQs),
        .tw_idx(tw_idx), .ovf(ovf)
    );
    mul_twf_pipe #(.DOUT_WIDTH(11)) dut_s (
        .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din_ready(din_ready_s),
        .sof(sof), .tw_auto(tw_auto), .select(select), .rnd_en(rnd_en),
        .din_R_add(dRa), .din_Q_add(dQa), .din_R_sub(dRs), .din_Q_sub(dQs),
        .dout_valid(dout_valid_s), .dout_ready(dout_ready),
        .dout_R_add(bRa), .dout_Q_add(bQa), .dout_R_sub(bRs), .dout_Q_sub(bQs),
        .tw_idx(tw_idx_s), .ovf(ovf_s)
    );

    always #5 clk = ~clk;

    function automatic longint fdiv(longint a, longint b);
        return (a >= 0) ? a / b : -((-a + b - 1) / b);
    endfunction

    // reference: complex rotation by W8^k, optional half-up rounding, floor, clamp
    function automatic int model(int l, int st, int k, bit rn, int dw, output bit clip);
        longint r, q, v, hi;
        r = (st < 2) ? longint'(dRa[l]) : longint'(dRs[l]);
        q = (st < 2) ? longint'(dQa[l]) : longint'(dQs[l]);
        v = (st % 2 == 0) ? r * tc[k] - q * td[k] : r * td[k] + q * tc[k];
        v = fdiv(v + (rn ? 128 : 0), 256);
        hi = (longint'(1) << (dw - 1)) - 1;
        clip = (v > hi) || (v < -hi - 1);
        return int'(v > hi ? hi : (v < -hi - 1 ? -hi - 1 : v));
    endfunction

    function automatic int act(int w, int j);
        int l, st;
        l = j / 4;
        st = j % 4;
        if (w == 0) begin
            if (st == 0) return int'(aRa[l]);
            if (st == 1) return int'(aQa[l]);
            if (st == 2) return int'(aRs[l]);
            return int'(aQs[l]);
        end
        if (st == 0) return int'(bRa[l]);
        if (st == 1) return int'(bQa[l]);
        if (st == 2) return int'(bRs[l]);
        return int'(bQs[l]);
    endfunction

    task automatic chk(string name, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic set_all(int r, int q);
        for (int l = 0; l < DEPTH; l++) begin
            dRa[l] = 11'(r); dQa[l] = 11'(q); dRs[l] = 11'(r); dQs[l] = 11'(q);
        end
    endtask

    task automatic set_rand();
        for (int l = 0; l < DEPTH; l++) begin
            dRa[l] = 11'($urandom_range(0, 2047)); dQa[l] = 11'($urandom_range(0, 2047));
            dRs[l] = 11'($urandom_range(0, 2047)); dQs[l] = 11'($urandom_range(0, 2047));
        end
    endtask

    // call at posedge+1; returns at posedge+1 after the acceptance edge
    task automatic issue(bit s, bit a, logic [2:0] sel, bit rn);
        int n = 0;
        int k;
        bit c;
        exp_t e;
        sof = s; tw_auto = a; select = sel; rnd_en = rn; din_valid = 1'b1;
        @(negedge clk);
        while (!din_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!din_ready) begin
            chk("accept_timeout", 0, 1);
        end else begin
            k = a ? (s ? 0 : m_auto) : int'(sel);
            if (s) m_auto = 1;
            else if (a) m_auto = (m_auto + 1) % 8;
            for (int w = 0; w < 2; w++) begin
                for (int j = 0; j < 64; j++) begin
                    e.v[w][j] = model(j / 4, j % 4, k, rn, w ? 11 : 13, c);
                    m_ov[w] = m_ov[w] | c;
                end
                e.ov[w] = m_ov[w];
            end
            sb.push_back(e);
            @(posedge clk);
            #1;
            chk("tw_idx", int'(tw_idx), k);
            chk("tw_idx_s", int'(tw_idx_s), k);
        end
        din_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_pending", sb.size(), 0);
    endtask

    // monitor: every accepted output beat is compared against the oldest expectation
    always @(negedge clk) begin
        if (rst_n && dout_valid && dout_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                for (int w = 0; w < 2; w++) begin
                    int bad = -1;
                    for (int j = 0; j < 64; j++)
                        if (bad < 0 && act(w, j) != e.v[w][j]) bad = j;
                    checks++;
                    if (bad >= 0) begin
                        errors++;
                        $display("FAIL data w%0d lane%0d st%0d: got %0d expected %0d",
                                 w, bad / 4, bad % 4, act(w, bad), e.v[w][bad]);
                    end
                end
                chk("ovf", int'(ovf), int'(e.ov[0]));
                chk("ovf_s", int'(ovf_s), int'(e.ov[1]));
                chk("dout_valid_s", int'(dout_valid_s), 1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int snap;
        set_all(0, 0);
        repeat (3) @(negedge clk);
        chk("rst_dout_valid", int'(dout_valid), 0);
        chk("rst_din_ready", int'(din_ready), 1);
        chk("rst_tw_idx", int'(tw_idx), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_dout", int'(aRa[0]), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // basic rotation, truncate then round, explicit 3-cycle latency
        for (int rn = 0; rn < 2; rn++) begin
            set_all(10, 8);
            issue(0, 0, 3'd1, rn[0]);
            @(posedge clk);
            #1;
            chk("lat_early", int'(dout_valid), 0);
            @(posedge clk);
            #1;
            chk("lat_valid", int'(dout_valid), 1);
            chk("basic_R", int'(aRs[7]), rn ? 13 : 12);
            chk("basic_Q", int'(aQa[3]), rn ? -1 : -2);
            drain();
        end

        // saturation in the 11-bit copy
        set_all(1023, 1023);
        issue(0, 0, 3'd1, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("sat_R", int'(bRa[0]), 1023);
        chk("sat_Q", int'(bQs[15]), 0);
        chk("sat_ovf", int'(ovf_s), 1);
        chk("sat_ovf_wide", int'(ovf), 0);
        set_all(3, -5);
        issue(0, 0, 3'd2, 1);
        drain();
        chk("ovf_sticky", int'(ovf_s), 1);

        // automatic twiddle sequence with sof on the first beat
        for (int i = 0; i < 10; i++) begin
            set_rand();
            issue(i == 0, 1, 3'd5, 0);
            chk("auto_seq", int'(tw_idx), seq[i]);
        end
        drain();

        // stall with a full pipe
        done = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    set_rand();
                    issue(0, $urandom_range(0, 1), 3'($urandom_range(0, 7)), $urandom_range(0, 1));
                end
            end
            begin
                int n = 0;
                while (!dout_valid && n < 50) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                chk("stall_reach_valid", int'(dout_valid), 1);
                dout_ready = 1'b0;
                @(negedge clk);
                snap = int'(aRa[0]);
                for (int c = 0; c < 4; c++) begin
                    @(negedge clk);
                    chk("stall_frozen", int'(aRa[0]), snap);
                    chk("stall_hold", {31'd0, dout_valid} + {30'd0, din_ready, 1'b0} + {29'd0, din_ready_s, 2'b0}, 1);
                end
                @(posedge clk);
                #1;
                dout_ready = 1'b1;
            end
        join
        drain();

        // reset with two beats in flight
        set_rand();
        issue(1, 1, 3'd0, 0);
        issue(0, 1, 3'd0, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", int'(dout_valid), 0);
        chk("mid_rst_valid_s", int'(dout_valid_s), 0);
        chk("mid_rst_tw_idx", int'(tw_idx), 0);
        chk("mid_rst_ovf_s", int'(ovf_s), 0);
        sb.delete();
        m_auto = 0;
        m_ov = '{0, 0};
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        set_rand();
        issue(0, 1, 3'd6, 0);
        chk("post_rst_auto_k", int'(tw_idx), 0);
        drain();

        // randomized traffic with random backpressure
        done = 0;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    set_rand();
                    issue($urandom_range(0, 7) == 0, $urandom_range(0, 1),
                          3'($urandom_range(0, 7)), $urandom_range(0, 1));
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    dout_ready = $urandom_range(0, 3) != 0;
                end
                dout_ready = 1'b1;
            end
        join
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
